// File: rtl/xcvr_bus_ctrl.sv
// Purpose : Host-to-external-bus controller driving a bidirectional transceiver
//           (DIR/OE), with chip select, write strobe and read data capture.
// Latency : SETUP_CYC+STROBE_CYC+HOLD_CYC cycles from acceptance back to ready,
//           +1 when a transceiver turnaround (TURN) is needed. Optional macro
//           XCVR_BUS_CTRL_WAIT_EN adds bus_wait_n to stretch the strobe.
// Backpressure: one transaction at a time; req is only taken while ready=1.
//
// Ports:
//   clock, reset           - single clock, synchronous active-high reset
//   req/we/addr/wdata      - host request; accepted on req && ready
//   ready/rdata/rvalid     - idle flag, read result, one-cycle result pulse
//   bus_addr/bus_cs_n/bus_we_n - external address, chip select, write strobe
//   xcvr_dir/xcvr_oe_n     - transceiver direction (1 = A->B write) and enable
//   data_out/data_oe/data_in - A-side data driver, its enable, and read input
//   bus_wait_n             - (XCVR_BUS_CTRL_WAIT_EN only) active-low wait
module xcvr_bus_ctrl #(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic        ready,
   output logic [7:0]  rdata,
   output logic        rvalid,
   output logic [15:0] bus_addr,
   output logic        bus_cs_n,
   output logic        bus_we_n,
   output logic        xcvr_dir,
   output logic        xcvr_oe_n,
   output logic [7:0]  data_out,
   output logic        data_oe,
`ifdef XCVR_BUS_CTRL_WAIT_EN
   input  logic        bus_wait_n,
`endif
   input  logic [7:0]  data_in
);

   if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
      $error("xcvr_bus_ctrl: SETUP_CYC, STROBE_CYC and HOLD_CYC must all be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_TURN,
      S_SETUP,
      S_STROBE,
      S_HOLD
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        lat_we;
   logic        accept;
   logic        capture;
   logic        wait_ok;

`ifdef XCVR_BUS_CTRL_WAIT_EN
   assign wait_ok = bus_wait_n;
`else
   assign wait_ok = 1'b1;
`endif

   // Counter holds "cycles remaining minus one" in the current state; it is
   // reloaded on every state entry and the state exits when it reads zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (we != xcvr_dir) begin
                  state_d = S_TURN;
                  cnt_d   = 16'd0;
               end else begin
                  state_d = S_SETUP;
                  cnt_d   = 16'(SETUP_CYC - 1);
               end
            end
         end
         S_TURN: begin
            state_d = S_SETUP;
            cnt_d   = 16'(SETUP_CYC - 1);
         end
         S_SETUP: begin
            if (cnt_q == 16'd0) begin
               state_d = S_STROBE;
               cnt_d   = 16'(STROBE_CYC - 1);
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_STROBE: begin
            if (cnt_q == 16'd0) begin
               // Last strobe cycle: stay put (counter parked at 0) while the
               // target asserts wait; capture read data on release.
               if (wait_ok) begin
                  state_d = S_HOLD;
                  cnt_d   = 16'(HOLD_CYC - 1);
                  capture = ~lat_we;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_HOLD: begin
            if (cnt_q == 16'd0) begin
               state_d = S_IDLE;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   // Bus-side strobes are pure decodes of state; addresses, direction and
   // data are registers so they hold their values across IDLE.
   always_comb begin
      ready     = (state_q == S_IDLE);
      bus_cs_n  = 1'b1;
      bus_we_n  = 1'b1;
      xcvr_oe_n = 1'b1;
      data_oe   = 1'b0;
      case (state_q)
         S_SETUP: begin
            bus_cs_n = 1'b0;
            data_oe  = lat_we;
         end
         S_STROBE: begin
            bus_cs_n  = 1'b0;
            xcvr_oe_n = 1'b0;
            bus_we_n  = ~lat_we;
            data_oe   = lat_we;
         end
         S_HOLD: begin
            bus_cs_n = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 16'd0;
         lat_we   <= 1'b0;
         bus_addr <= 16'd0;
         data_out <= 8'd0;
         xcvr_dir <= 1'b0;
         rdata    <= 8'd0;
         rvalid   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rvalid  <= capture;
         if (accept) begin
            lat_we   <= we;
            bus_addr <= addr;
            data_out <= wdata;
            // Only differs from the current value when TURN is entered, so
            // the direction flips at the edge into TURN with OE still high.
            xcvr_dir <= we;
         end
         if (capture) begin
            rdata <= data_in;
         end
      end
   end

endmodule
